// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: states, command/error codes and ASCII constants for uart_cmd_decoder
package uart_cmd_pkg;
  typedef enum logic [1:0] {IDLE, ARG, WAIT_CR, FLUSH} state_t;
  localparam logic [2:0] CMD_TIME = 3'd1, CMD_POWER = 3'd2, CMD_START = 3'd3, CMD_CANCEL = 3'd4;
  localparam logic [2:0] ERR_UNKNOWN = 3'd1, ERR_BADCHAR = 3'd2, ERR_RANGE = 3'd3, ERR_NOARG = 3'd4, ERR_TIMEOUT = 3'd5;
  localparam logic [7:0] ASCII_CR = 8'h0D, ASCII_LF = 8'h0A, ASCII_0 = 8'h30, ASCII_9 = 8'h39;
  localparam logic [7:0] ASCII_T = 8'h54, ASCII_P = 8'h50, ASCII_S = 8'h53, ASCII_X = 8'h58;
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c & 8'hDF) : c;
  endfunction
endpackage

// File: rtl/cmd_timeout_ctr.sv
// cmd_timeout_ctr: inter-byte tick counter; pulses expire on the tick that reaches LIMIT
module cmd_timeout_ctr #(
  parameter logic [15:0] LIMIT = 16'd40000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic tick,
  output logic expire
);
  logic [15:0] cnt;
  // a byte arriving in the same cycle wins over expiry
  assign expire = en && tick && !clr && (cnt == LIMIT - 16'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || !en || expire) cnt <= '0;
    else if (tick) cnt <= cnt + 16'd1;
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses CR-terminated ASCII commands (T/P/S/X) into code+arg or an error code.
// Define CMD_TIMEOUT_EN to abort a partial command after TIMEOUT_TICKS ticks with no byte.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [13:0] MAX_SECS      = 14'd5999,
  parameter logic [2:0]  MAX_DIGITS    = 3'd4,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        tick,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [13:0] cmd_arg,
  output logic        err_valid,
  output logic [2:0]  err_code
);
  state_t state, state_n;
  logic [13:0] acc, acc_n, acc10;
  logic [2:0] cnt, cnt_n, pend, pend_n, err_n;
  logic cmd_fire, err_fire, is_digit, expire;
  logic [7:0] ch;

`ifdef CMD_TIMEOUT_EN
  cmd_timeout_ctr #(.LIMIT(TIMEOUT_TICKS)) u_timeout (
    .clk(clk), .rst(rst), .en(state != IDLE), .clr(rx_valid), .tick(tick), .expire(expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = tick ^ (^TIMEOUT_TICKS);
  assign expire = 1'b0;
`endif

  assign ch = to_upper(rx_byte);
  assign is_digit = rx_byte >= ASCII_0 && rx_byte <= ASCII_9;
  assign acc10 = {acc[10:0], 3'b000} + {acc[12:0], 1'b0};

  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    pend_n = pend;
    cmd_fire = 1'b0;
    err_fire = 1'b0;
    err_n = err_code;
    if (rx_valid)
      case (state)
        IDLE:
          if (ch == ASCII_T || ch == ASCII_P) begin
            acc_n = '0;
            cnt_n = '0;
            pend_n = (ch == ASCII_T) ? CMD_TIME : CMD_POWER;
            state_n = ARG;
          end else if (ch == ASCII_S || ch == ASCII_X) begin
            acc_n = '0;
            pend_n = (ch == ASCII_S) ? CMD_START : CMD_CANCEL;
            state_n = WAIT_CR;
          end else if (ch != ASCII_CR && ch != ASCII_LF) begin
            err_fire = 1'b1;
            err_n = ERR_UNKNOWN;
            state_n = FLUSH;
          end
        ARG:
          if (is_digit) begin
            if (cnt == MAX_DIGITS || (pend == CMD_POWER && cnt != 3'd0)) begin
              err_fire = 1'b1;
              err_n = ERR_RANGE;
              state_n = FLUSH;
            end else begin
              acc_n = acc10 + {10'd0, rx_byte[3:0]};
              cnt_n = cnt + 3'd1;
            end
          end else if (rx_byte == ASCII_CR) begin
            state_n = IDLE;
            err_fire = cnt == 3'd0 || ((pend == CMD_TIME) ? acc > MAX_SECS : acc == '0);
            err_n = (cnt == 3'd0) ? ERR_NOARG : err_fire ? ERR_RANGE : err_code;
            cmd_fire = !err_fire;
          end else begin
            err_fire = 1'b1;
            err_n = ERR_BADCHAR;
            state_n = FLUSH;
          end
        WAIT_CR: begin
          cmd_fire = rx_byte == ASCII_CR;
          err_fire = !cmd_fire;
          err_n = cmd_fire ? err_code : ERR_BADCHAR;
          state_n = cmd_fire ? IDLE : FLUSH;
        end
        FLUSH: state_n = (rx_byte == ASCII_CR) ? IDLE : FLUSH;
        default: state_n = IDLE;
      endcase
    if (expire) begin
      state_n = IDLE;
      acc_n = '0;
      cnt_n = '0;
      err_fire = 1'b1;
      err_n = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      pend <= '0;
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      cmd_code <= '0;
      cmd_arg <= '0;
      err_code <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      pend <= pend_n;
      cmd_valid <= cmd_fire;
      err_valid <= err_fire;
      err_code <= err_n;
      if (cmd_fire) begin
        cmd_code <= pend;
        cmd_arg <= acc;
      end
    end
endmodule
